// File: rtl/mux3_pkg.sv
// ============================================================================
// mux3_pkg : shared select codes, FSM states and default widths for the
//            three-way round-robin byte scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mux3_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int OUT_W_DEF  = 16;
   localparam int CNT_W_DEF  = 16;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_A    = 2'b01;
   localparam logic [1:0] SEL_B    = 2'b10;
   localparam logic [1:0] SEL_C    = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Requester index 0..2 (A..C) to its external select code.
   function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
      logic [1:0] sel;
      case (idx)
         2'd0:    sel = SEL_A;
         2'd1:    sel = SEL_B;
         2'd2:    sel = SEL_C;
         default: sel = SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick3.sv
// ============================================================================
// rr_pick3 : combinational round-robin pick among three requesters, searching
//            from the requester after `last` in the order A -> B -> C -> A.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick3
   import mux3_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [1:0] win_sel,
   output logic [2:0] win_oh
);

   logic [1:0] start_idx;
   logic [1:0] cand_idx;
   logic       found;

   // A SEL_NONE pointer is treated like C so A is searched first.
   always_comb begin
      case (last)
         SEL_A:   start_idx = 2'd1;
         SEL_B:   start_idx = 2'd2;
         default: start_idx = 2'd0;
      endcase
   end

   always_comb begin
      win_sel  = SEL_NONE;
      win_oh   = 3'b000;
      found    = 1'b0;
      cand_idx = start_idx;
      for (int k = 0; k < 3; k++) begin
         if (!found && req[cand_idx]) begin
            found   = 1'b1;
            win_sel = idx_to_sel(cand_idx);
            win_oh  = 3'b001 << cand_idx;
         end
         cand_idx = (cand_idx == 2'd2) ? 2'd0 : cand_idx + 2'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mux3_rr_sched.sv
// ============================================================================
// mux3_rr_sched : round-robin scheduler sharing a three-input byte mux; the
//                 chosen byte is captured zero-extended and offered on a
//                 valid/ready interface.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux3_rr_sched
   import mux3_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OUT_W  = OUT_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        req,
   input  logic [DATA_W-1:0] in_A,
   input  logic [DATA_W-1:0] in_B,
   input  logic [DATA_W-1:0] in_C,
   input  logic              out_ready,
   output logic [2:0]        grant,
   output logic [1:0]        select,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_valid,
   output logic              busy,
   output logic [CNT_W-1:0]  xfer_count
);

   state_e            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        last_q, last_d;
   logic [2:0]        grant_q, grant_d;
   logic [OUT_W-1:0]  data_q, data_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [1:0]        win_sel;
   logic [2:0]        win_oh;
   logic [DATA_W-1:0] win_byte;

   rr_pick3 u_pick (
      .req     (req),
      .last    (last_q),
      .win_sel (win_sel),
      .win_oh  (win_oh)
   );

   always_comb begin
      case (win_sel)
         SEL_A:   win_byte = in_A;
         SEL_B:   win_byte = in_B;
         SEL_C:   win_byte = in_C;
         default: win_byte = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      grant_d = 3'b000;
      data_d  = data_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req != 3'b000) begin
               data_d  = OUT_W'(win_byte);
               sel_d   = win_sel;
               grant_d = win_oh;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_HOLD;
            end else begin
               sel_d = SEL_NONE;
            end
         end
         ST_HOLD: begin
            // The pointer advances only once the consumer has taken the word.
            if (valid_q && out_ready) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               sel_d   = SEL_NONE;
               last_d  = sel_q;
               cnt_d   = cnt_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= SEL_NONE;
         last_q  <= SEL_C;
         grant_q <= 3'b000;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant      = grant_q;
   assign select     = sel_q;
   assign out_data   = data_q;
   assign out_valid  = valid_q;
   assign busy       = busy_q;
   assign xfer_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mux3_rr_sched.sv
// ============================================================================
// tb_mux3_rr_sched : directed and randomized bench for mux3_rr_sched checked
//                    against a transaction-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux3_rr_sched;

   localparam int DATA_W = 8;
   localparam int OUT_W  = 16;
   localparam int CNT_W  = 6;   // narrow counter so wrap-around is reachable quickly

   logic              clk = 1'b0;
   logic              rst;
   logic [2:0]        req;
   logic [DATA_W-1:0] in_A, in_B, in_C;
   logic              out_ready;
   logic [2:0]        grant;
   logic [1:0]        select;
   logic [OUT_W-1:0]  out_data;
   logic              out_valid;
   logic              busy;
   logic [CNT_W-1:0]  xfer_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: who is being served and what word was taken.
   bit        m_hold;
   int        m_who;
   int        m_last;
   int        m_word;
   int        m_grant;
   int        m_cnt;
   int        m_wraps;

   always #5 clk = ~clk;

   mux3_rr_sched #(
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .in_A       (in_A),
      .in_B       (in_B),
      .in_C       (in_C),
      .out_ready  (out_ready),
      .grant      (grant),
      .select     (select),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .busy       (busy),
      .xfer_count (xfer_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      int bytes[3];
      bytes[0] = in_A;
      bytes[1] = in_B;
      bytes[2] = in_C;
      if (rst) begin
         m_hold = 0; m_word = 0; m_grant = 0; m_cnt = 0; m_last = 2; m_who = -1;
      end else begin
         m_grant = 0;
         if (!m_hold) begin
            for (int k = 1; k <= 3; k++) begin
               int idx;
               idx = (m_last + k) % 3;
               if (!m_hold && req[idx]) begin
                  m_hold  = 1;
                  m_who   = idx;
                  m_word  = bytes[idx];
                  m_grant = 1 << idx;
               end
            end
         end else if (out_ready) begin
            m_hold = 0;
            m_last = m_who;
            m_cnt  = m_cnt + 1;
            if (m_cnt == (1 << CNT_W)) begin
               m_cnt = 0;
               m_wraps++;
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic [2:0] rq, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c, input logic rdy);
      rst = r; req = rq; in_A = a; in_B = b; in_C = c; out_ready = rdy;
      @(posedge clk);
      model_edge();
      #1;
      check("out_valid",  32'(out_valid),  32'(m_hold));
      check("busy",       32'(busy),       32'(m_hold));
      check("select",     32'(select),     m_hold ? 32'(m_who + 1) : 32'd0);
      check("grant",      32'(grant),      32'(m_grant));
      check("out_data",   32'(out_data),   32'(m_word));
      check("xfer_count", 32'(xfer_count), 32'(m_cnt));
   endtask

   initial begin
      m_wraps = 0;
      // Reset, then three contending requesters served A, B, C in turn.
      step(1, 3'b000, 8'h00, 8'h00, 8'h00, 0);
      step(1, 3'b000, 8'h00, 8'h00, 8'h00, 0);
      check("reset_last_ptr", 32'(m_last), 32'd2);
      for (int i = 0; i < 6; i++) step(0, 3'b111, 8'h02, 8'h04, 8'h01, 1);
      check("three_xfers", 32'(xfer_count), 32'd3);

      // Long HOLD with consumer stalled, then a changing producer during HOLD.
      step(1, 3'b000, 8'h00, 8'h00, 8'h00, 0);
      step(0, 3'b001, 8'hFF, 8'h00, 8'h00, 0);
      for (int i = 0; i < 5; i++) step(0, 3'b000, 8'h55, 8'h00, 8'h00, 0);
      check("stall_word", 32'(out_data), 32'h00FF);
      step(0, 3'b000, 8'h55, 8'h00, 8'h00, 1);
      check("stall_count", 32'(xfer_count), 32'd1);
      step(0, 3'b000, 8'h55, 8'h00, 8'h00, 1);   // ready with no valid is ignored

      // Reset in the middle of HOLD drops the word; A wins afterwards.
      step(0, 3'b010, 8'h00, 8'h33, 8'h00, 0);
      step(1, 3'b000, 8'h00, 8'h00, 8'h00, 0);
      step(0, 3'b111, 8'h11, 8'h22, 8'h33, 0);
      check("post_rst_grant", 32'(grant), 32'b001);
      step(0, 3'b000, 8'h11, 8'h22, 8'h33, 1);

      // A and C held: alternation without ever granting B.
      for (int i = 0; i < 8; i++) begin
         step(0, 3'b101, 8'($urandom), 8'($urandom), 8'($urandom), 1);
         check("no_b_grant", 32'(grant[1]), 32'd0);
      end

      // Continuous traffic long enough to wrap the transfer counter.
      for (int i = 0; i < 140; i++) step(0, 3'b111, 8'(i), 8'(i + 1), 8'(i + 2), 1);
      check("counter_wrapped", 32'(m_wraps > 0), 32'd1);

      // Randomized traffic with sporadic resets and stalls.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0), 3'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mux3_rr_sched.md
Name: mux3_rr_sched

Overview:
Round-robin scheduler that shares the three-input byte mux between three requesters (A, B, C).
- Arbitrates the requests and drives the 2-bit select code.
- Captures the chosen byte zero-extended to 16 bits.
- Presents the 16-bit word to a downstream consumer over a valid/ready handshake.
- Sits between the three byte producers and the 16-bit result consumer; the select output also steers the external mux.

Parameters:
DATA_W, 8, width of each input byte
OUT_W, 16, width of output word (OUT_W >= DATA_W; upper bits zero-filled)
CNT_W, 16, width of transfer counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req  in  3  request: bit0=A, bit1=B, bit2=C
in_A  in  DATA_W  data of requester A
in_B  in  DATA_W  data of requester B
in_C  in  DATA_W  data of requester C
out_ready  in  1  consumer accepts word
grant  out  3  one-hot, one-cycle pulse to the served requester
select  out  2  mux select: 00 none, 01 A, 10 B, 11 C
out_data  out  OUT_W  captured word, zero-extended
out_valid  out  1  out_data valid
busy  out  1  high while in HOLD
xfer_count  out  CNT_W  completed transfers, wraps

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst); all state changes on rising clk.
- Reset values:
  - state=IDLE; select=00; grant=000; out_data=0; out_valid=0; busy=0; xfer_count=0.
  - last pointer=C, so A has first priority after reset.
  - Reset asserted mid-transfer discards the pending word without incrementing xfer_count.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - req==000: remain in IDLE with select=00.
  - Otherwise pick the winner round-robin, searching from last+1 (C->A->B->C).
  - At the clock edge: register the winner's byte into out_data[DATA_W-1:0] with upper bits 0; set select to the winner's code; set out_valid=1 and busy=1; set grant to the winner's one-hot bit (high for exactly this one following cycle); enter HOLD.
- HOLD:
  - out_data and select are held stable; grant returns to 000 after its single cycle.
  - On out_valid && out_ready at an edge: out_valid=0, busy=0, select=00, last=winner, xfer_count+=1 (mod 2^CNT_W), enter IDLE.
  - Without out_ready, HOLD persists indefinitely with no timeout.
- Timing:
  - Latency is 1 cycle from the req sample edge to out_valid.
  - Maximum throughput is one word per 2 cycles (IDLE bubble between transfers).
- Boundaries:
  - A requester that drops req or changes its data during HOLD does not affect the captured word.
  - The pointer updates only on completed handshakes.
  - A requester whose req stays high is served again only after the other active requesters have each been served once.
  - xfer_count at all-ones wraps to 0 on the next transfer.
  - out_ready while out_valid=0 is ignored.

Decomposition:
- Package mux3_pkg holds:
  - select codes SEL_NONE=2'b00, SEL_A=2'b01, SEL_B=2'b10, SEL_C=2'b11;
  - state encoding ST_IDLE, ST_HOLD;
  - default widths.
- One natural combinational sub-module: rr_pick3 (inputs req[2:0] and last code; outputs a winner select code and a one-hot vector).
- Data capture, FSM and counter stay in the top module.

Test Plan:
1. rst for 2 cycles, then req=111, in_A=2, in_B=4, in_C=1, out_ready=1 -> three transfers in order with out_data 0x0002 (select 01), 0x0004 (select 10), 0x0001 (select 11); one grant pulse each, 2-cycle spacing; xfer_count=3.
2. req=001, in_A=0xFF, out_ready=0 for 5 cycles, then 1 -> out_valid rises 1 cycle after req; out_data=0x00FF and select=01 stable across all HOLD cycles; one acceptance; xfer_count=1.
3. req=001 during capture, then req=000 and in_A=0x55 during HOLD -> the word delivered is the originally captured value, not 0x55; select returns to 00 after the handshake.
4. rst asserted during HOLD with out_valid=1 -> next cycle all outputs 0 and xfer_count unchanged at 0; first grant after reset, with req=111, goes to A.
5. req=101 held continuously, out_ready=1 -> grants alternate A, C, A, C; B is never granted.
6. Preload xfer_count to 16'hFFFF (or run 65535 transfers), then one transfer -> xfer_count=0.
